// File: rtl/dac_sample_scheduler_pkg.sv
// dac_sample_scheduler_pkg: shared state encoding, default sizes and width helper for the DAC scheduler.
package dac_sample_scheduler_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int N_DEF = 12;
  localparam int NCH_DEF = 4;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dac_sample_scheduler_rr_arbiter.sv
// dac_sample_scheduler_rr_arbiter: picks the first requesting channel at or after the pointer, wrapping.
module dac_sample_scheduler_rr_arbiter
  import dac_sample_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  localparam int CW = clog2w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [CW-1:0]  o_idx,
  output logic           o_valid
);
  logic [CW-1:0] w_c;
  always_comb begin
    o_valid = 1'b0;
    o_idx = '0;
    w_c = '0;
    for (int k = 0; k < NCH; k++) begin
      w_c = CW'((int'(i_ptr) + k) % NCH);
      if (!o_valid && i_req[w_c]) begin
        o_valid = 1'b1;
        o_idx = w_c;
      end
    end
    o_grant = o_valid ? (NCH'(1) << o_idx) : '0;
  end
endmodule

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: round-robin sharing of one DAC, each granted code held for SETTLE cycles.
module dac_sample_scheduler
  import dac_sample_scheduler_pkg::*;
#(
  parameter int             N = N_DEF,
  parameter int             NCH = NCH_DEF,
  parameter int             SETTLE = 8,
  parameter logic [N-1:0]   IDLE_CODE = '0,
  localparam int            CW = clog2w(NCH),
  localparam int            SW = clog2w(SETTLE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [NCH-1:0]   i_req_valid,
  input  logic [NCH*N-1:0] i_req_code,
  output logic [NCH-1:0]   o_req_ready,
  output logic [N-1:0]     o_dac_din,
  output logic             o_dac_load,
  output logic             o_busy,
  output logic [CW-1:0]    o_cur_ch,
  output logic             o_done_valid,
  output logic [CW-1:0]    o_done_ch
);
  state_t        r_state;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_cur;
  logic [SW-1:0] r_cnt;
  logic [N-1:0]  r_din;
  logic          r_load;
  logic [NCH-1:0] w_grant;
  logic [CW-1:0] w_idx;
  logic          w_any;
  logic          w_accept;
  logic          w_done;
  logic [N-1:0]  w_code;

  dac_sample_scheduler_rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req  (i_req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_valid(w_any)
  );

  always_comb begin
    w_code = i_req_code[N-1:0];
    for (int c = 1; c < NCH; c++)
      if (w_idx == CW'(c)) w_code = i_req_code[c*N +: N];
  end

  assign w_accept = (r_state == IDLE) && i_en && w_any;
  assign w_done = (r_state == HOLD) && (r_cnt == '0);
  assign o_req_ready = w_accept ? w_grant : '0;
  assign o_dac_din = r_din;
  assign o_dac_load = r_load;
  assign o_busy = (r_state == HOLD);
  assign o_cur_ch = r_cur;
  assign o_done_valid = w_done;
  assign o_done_ch = w_done ? r_cur : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cur <= '0;
      r_cnt <= '0;
      r_din <= IDLE_CODE;
      r_load <= 1'b0;
    end else begin
      r_load <= w_accept;
      if (w_accept) begin
        r_state <= HOLD;
        r_din <= w_code;
        r_cur <= w_idx;
        r_cnt <= SW'(SETTLE - 1);
      end else if (w_done) begin
        r_state <= IDLE;
        r_ptr <= CW'((int'(r_cur) + 1) % NCH);
      end else if (r_state == HOLD) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule
